// File: rtl/decoder_3to8_pkg.sv
// Shared types for the queued 3-to-8 decoder.
// FSM states, FIFO entry layout and one-hot helper.
package decoder_3to8_pkg;

  localparam int ENTRY_W = 4;
  localparam int CNT_W   = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;

  typedef struct packed {
    logic       sympol;
    logic [2:0] code;
  } entry_t;

  // A cleared sympol means the encoder saw no bit set: show nothing.
  function automatic logic [7:0] onehot(entry_t e);
    return e.sympol ? (8'b1 << e.code) : 8'h00;
  endfunction

endpackage

// File: rtl/decoder_3to8_code_fifo.sv
// Small synchronous FIFO holding pending decoder entries.
// Occupancy counter carries the extra bit for full/empty.
module code_fifo
  import decoder_3to8_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ENTRY_W-1:0]       din,
  output logic [ENTRY_W-1:0]       dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_q, wr_d;
  logic [AW-1:0]      rd_q, rd_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic               do_push;
  logic               do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign level   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointer and occupancy next-state; pointers wrap naturally.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/decoder_3to8.sv
// Queued 3-to-8 one-hot decoder with per-code hold time.
// Codes are buffered, then each is shown for HOLD cycles.
module decoder_3to8
  import decoder_3to8_pkg::*;
#(
  parameter int HOLD  = 4,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_code,
  input  logic       in_sympol,
  output logic [7:0] D,
  output logic       out_valid,
  output logic       busy
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD - 1);

  state_e           state_q, state_d;
  logic [7:0]       d_q, d_d;
  logic             ov_q, ov_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  logic [LW-1:0] level_nxt;
  logic          push;
  logic          pop;
  logic          load;
  entry_t        head;
  entry_t        tail;

  assign in_ready = ~full & ~rst;
  assign push     = in_valid & in_ready;
  assign tail     = '{sympol: in_sympol, code: in_code};

  code_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (tail),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Next-state: pop and load on IDLE or at the end of a hold.
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    ov_d    = ov_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          load = 1'b1;
        end else begin
          d_d  = 8'h00;
          ov_d = 1'b0;
        end
      end
      SHOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!empty) begin
          load = 1'b1;
        end else begin
          d_d     = 8'h00;
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      d_d     = onehot(head);
      ov_d    = 1'b1;
      cnt_d   = HOLD_M1;
      state_d = SHOW;
    end
    pop       = load;
    level_nxt = level + LW'(push) - LW'(pop);
    busy_d    = (level_nxt != '0) || (state_d == SHOW);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      d_q     <= 8'h00;
      ov_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      ov_q    <= ov_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign D         = d_q;
  assign out_valid = ov_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_decoder_3to8.sv
// Bench for decoder_3to8: HOLD=4 and HOLD=1 instances.
// Schedule-based model plus directed literal checks.
module tb_decoder_3to8;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_code;
  logic       in_sympol;

  logic       r0, r1;
  logic [7:0] d0, d1;
  logic       ov0, ov1;
  logic       b0, b1;

  decoder_3to8 #(.HOLD(4), .DEPTH(DEPTH)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r0),
    .in_code(in_code), .in_sympol(in_sympol),
    .D(d0), .out_valid(ov0), .busy(b0)
  );

  decoder_3to8 #(.HOLD(1), .DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r1),
    .in_code(in_code), .in_sympol(in_sympol),
    .D(d1), .out_valid(ov1), .busy(b1)
  );

  always #5 clk = ~clk;

  // Each accepted entry: owning dut, push edge, first show edge.
  typedef struct {
    int         k;
    int         p;
    int         s;
    logic       sy;
    logic [2:0] cd;
  } ent_t;

  ent_t mq[$];
  int   lend[2];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   chk_on = 0;

  function automatic int hv(int k);
    return (k == 0) ? 4 : 1;
  endfunction

  // Entries held in the FIFO after edge c.
  function automatic int mcount(int k, int c);
    int n = 0;
    foreach (mq[i])
      if (mq[i].k == k && mq[i].p <= c && mq[i].s > c) n++;
    return n;
  endfunction

  function automatic void mdisp(input int k, input int c,
                                output logic ov, output logic [7:0] d);
    ov = 1'b0;
    d  = 8'h00;
    foreach (mq[i])
      if (mq[i].k == k && mq[i].s <= c && c < mq[i].s + hv(k)) begin
        ov = 1'b1;
        d  = mq[i].sy ? 8'(2 ** int'(mq[i].cd)) : 8'h00;
      end
  endfunction

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  // Advance the model across one rising edge using the applied inputs.
  task automatic model_edge();
    int   e;
    int   s;
    ent_t keep[$];
    e = cyc + 1;
    foreach (mq[i])
      if (!rst && mq[i].s + hv(mq[i].k) > e) keep.push_back(mq[i]);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        lend[k] = 0;
      end else if (in_valid && mcount(k, cyc) < DEPTH) begin
        s = (e + 1 > lend[k]) ? e + 1 : lend[k];
        keep.push_back('{k, e, s, in_sympol, in_code});
        lend[k] = s + hv(k);
      end
    end
    mq  = keep;
    cyc = e;
  endtask

  task automatic cycle(input bit v, input logic [2:0] c,
                       input bit s, input bit r);
    in_valid  = v;
    in_code   = c;
    in_sympol = s;
    rst       = r;
    @(negedge clk);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  // Every-cycle comparison of both instances against the model.
  initial begin
    logic       eov, erdy, ebusy;
    logic [7:0] ed;
    forever begin
      @(negedge clk);
      if (chk_on) begin
        for (int k = 0; k < 2; k++) begin
          mdisp(k, cyc, eov, ed);
          erdy  = !rst && (mcount(k, cyc) < DEPTH);
          ebusy = eov || (mcount(k, cyc) > 0);
          chk($sformatf("m%0d_D", k),    k ? d1 : d0,   ed);
          chk($sformatf("m%0d_ov", k),   k ? ov1 : ov0, 8'(eov));
          chk($sformatf("m%0d_busy", k), k ? b1 : b0,   8'(ebusy));
          chk($sformatf("m%0d_rdy", k),  k ? r1 : r0,   8'(erdy));
        end
      end
    end
  end

  initial begin
    logic [7:0] tr[16];
    int         c3[3];
    int         n;
    bit         saw;
    bit         v;
    bit         rm;

    rst = 1'b1; in_valid = 1'b0; in_code = 3'd0; in_sympol = 1'b0;
    cycle(1'b0, 3'd0, 1'b0, 1'b1);
    chk_on = 1;
    cycle(1'b0, 3'd0, 1'b0, 1'b1);
    chk("rst_D", d0, 8'h00);
    chk("rst_ov", ov0, 8'h0);
    chk("rst_busy", b0, 8'h0);

    // Single code 5 with symbol set.
    cycle(1'b1, 3'd5, 1'b1, 1'b0);
    chk("single_pre_ov", ov0, 8'h0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("single_D", d0, 8'h20);
      chk("single_ov", ov0, 8'h1);
    end
    idle(1);
    chk("single_end_D", d0, 8'h00);
    chk("single_end_ov", ov0, 8'h0);
    chk("single_end_busy", b0, 8'h0);
    idle(4);

    // Back-to-back 0, 7, 3.
    c3 = '{0, 7, 3};
    for (int i = 0; i < 14; i++) begin
      cycle(i < 3, (i < 3) ? 3'(c3[i]) : 3'd0, 1'b1, 1'b0);
      tr[i] = d0;
    end
    for (int i = 0; i < 14; i++)
      chk($sformatf("b2b_%0d", i), tr[i],
          (i == 0 || i >= 13) ? 8'h00 :
          (i <= 4) ? 8'h01 : (i <= 8) ? 8'h80 : 8'h08);
    idle(2);

    // Six codes with in_valid held; FIFO fills.
    n = 0; saw = 0;
    for (int j = 0; j < 40; j++) begin
      v   = (n < 6);
      rm  = mcount(0, cyc) < DEPTH;
      saw = saw | !r0;
      cycle(v, 3'(n), 1'b1, 1'b0);
      if (v && rm) n++;
    end
    chk("full_ready_drop", 8'(saw), 8'h1);
    idle(2);

    // No-symbol entry still occupies its slot.
    cycle(1'b1, 3'd2, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("nosym_D", d0, 8'h00);
      chk("nosym_ov", ov0, 8'h1);
    end
    idle(1);
    chk("nosym_end_ov", ov0, 8'h0);
    idle(2);

    // Reset while showing with entries queued.
    for (int i = 0; i < 5; i++) cycle(1'b1, 3'(i), 1'b1, 1'b0);
    idle(2);
    chk("midrst_pre_busy", b0, 8'h1);
    cycle(1'b0, 3'd0, 1'b0, 1'b1);
    chk("midrst_D", d0, 8'h00);
    chk("midrst_ov", ov0, 8'h0);
    chk("midrst_busy", b0, 8'h0);
    chk("midrst_busy1", b1, 8'h0);
    rst = 1'b0;
    #1;
    chk("midrst_rdy", r0, 8'h1);
    cycle(1'b1, 3'd6, 1'b1, 1'b0);
    idle(1);
    chk("post_rst_D", d0, 8'h40);
    idle(6);

    // HOLD=1 walk through all eight codes.
    for (int i = 0; i < 10; i++) begin
      cycle(i < 8, 3'(i), 1'b1, 1'b0);
      tr[i] = d1;
    end
    for (int i = 0; i < 8; i++)
      chk($sformatf("walk_%0d", i), tr[i+1], 8'(1 << i));
    idle(40);

    // Random traffic with occasional reset.
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 3) != 0, 3'($urandom), 1'($urandom),
            $urandom_range(0, 99) == 0);
    idle(30);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decoder_3to8.md
DECODER_3TO8 -- requirements
Module: decoder_3to8

Interface
REQ-001 The module SHALL have parameter HOLD, default 4, meaning display cycles per decoded code (legal range 1..255).
REQ-002 The module SHALL have parameter DEPTH, default 4, meaning input FIFO entries (power of two, at least 2).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port in_valid, input, 1 bit: a code is offered.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the FIFO can accept a code.
REQ-007 The module SHALL have port in_code, input, 3 bits: encoded index (0..7).
REQ-008 The module SHALL have port in_sympol, input, 1 bit: the symbol-valid flag from the encoder; 0 means no input bit was set.
REQ-009 The module SHALL have port D, output, 8 bits: registered one-hot decode.
REQ-010 The module SHALL have port out_valid, output, 1 bit: D is currently showing a code.
REQ-011 The module SHALL have port busy, output, 1 bit: the FIFO is non-empty or the state is SHOW.

Function
REQ-012 A transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; {in_sympol, in_code} is pushed into the FIFO tail.
REQ-013 in_ready SHALL equal !full, combinationally, and SHALL be 0 while rst=1; a full FIFO SHALL NOT accept a transfer even if a pop happens in the same cycle.
REQ-014 in_valid without in_ready SHALL cause no state change; the offered data is not captured.
REQ-015 The FSM SHALL have two states: IDLE and SHOW.
REQ-016 IDLE with the FIFO empty: hold D=0, out_valid=0.
REQ-017 IDLE with the FIFO non-empty: pop the head and, on the same edge, load D = sympol ? (8'b1 << code) : 8'h00, set out_valid=1, load counter=HOLD-1, and go to SHOW.
REQ-018 SHOW with counter>0: decrement counter; D and out_valid hold.
REQ-019 SHOW with counter=0 and the FIFO non-empty: pop and load the next entry per REQ-017, staying in SHOW with no gap cycle.
REQ-020 SHOW with counter=0 and the FIFO empty: D=0, out_valid=0, go to IDLE.
REQ-021 Each popped entry SHALL drive D and out_valid=1 for exactly HOLD consecutive cycles.
REQ-022 An entry with sympol=0 SHALL still occupy HOLD cycles with D=0 and out_valid=1.
REQ-023 Latency: a code pushed at edge t into an empty FIFO in IDLE SHALL appear on D after edge t+1.
REQ-024 A push into a FIFO whose only entry is being popped in the same cycle SHALL be accepted; the count is unchanged.
REQ-025 FIFO pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; full/empty SHALL be derived from an extra count bit, not from pointer equality alone.
REQ-026 The counter SHALL be 8 bits; HOLD=1 SHALL yield one cycle per code, back-to-back.
REQ-027 Entries SHALL be shown in push order; none SHALL be dropped or duplicated.

Reset
REQ-028 On a rising edge with rst=1, the design SHALL set state=IDLE, D=8'h00, out_valid=0, counter=0, and FIFO pointers and count to 0.
REQ-029 Reset asserted mid-SHOW or with a non-empty FIFO SHALL discard all pending codes; outputs SHALL be at their reset values after that edge.
REQ-030 The first transfer SHALL be possible on the first edge after rst deasserts.

Structure
REQ-031 The FSM state encoding and the FIFO entry width (4 bits) SHALL be defined in a shared package.
REQ-032 The FIFO SHALL be a separate sub-module, code_fifo (parameter DEPTH, width 4, push/pop/full/empty).
REQ-033 All outputs except in_ready SHALL be registered.

Verification
REQ-034 Single code: after reset, push code=5, sympol=1 -> D=8'h20 with out_valid=1 from edge t+1 for 4 cycles, then D=0, out_valid=0, busy=0.
REQ-035 Back-to-back codes: push 0, 7, 3 consecutively (HOLD=4) -> D=01, 80, 08, each for 4 cycles, no gap, 12 cycles total.
REQ-036 Full FIFO: with DEPTH=4, push 6 codes with in_valid held -> in_ready drops after the FIFO fills, no code lost, all 6 shown in order.
REQ-037 No symbol: push sympol=0, code=2 -> D=0 with out_valid=1 for 4 cycles.
REQ-038 Mid-operation reset: rst=1 for one cycle in the 2nd SHOW cycle with 3 entries queued -> next cycle D=0, out_valid=0, busy=0, in_ready=1.
REQ-039 HOLD=1 with 8 pushed codes 0..7 -> D walks 01 through 80, one per cycle, and the FIFO pointers wrap correctly.
